mult_16x9: RTL and testbench

Fully pipelined unsigned 16×9-bit multiplier producing an exact 25-bit product, with one result per clock and a fixed two-cycle latency. It is the arithmetic primitive for image-processing datapaths, such as pixel × coefficient in filters and colour-space conversion. It is built from explicit partial products and an adder tree rather than an inferred `*` operator, so the pipeline cut is deterministic.

---
 rtl/img_proc_pkg.sv | 17 +
 rtl/mult_16x9_if.sv | 23 ++
 rtl/mult_16x9_pp_gen.sv | 15 +
 rtl/mult_16x9.sv | 71 +++++++
 tb/tb_mult_16x9.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared widths and types for the image-processing multiplier
package img_proc_pkg;

  localparam int MULT_A_W = 16;
  localparam int MULT_B_W = 9;
  localparam int MULT_P_W = 25;

  typedef logic [MULT_A_W-1:0] mult_a_t;
  typedef logic [MULT_B_W-1:0] mult_b_t;
  typedef logic [MULT_P_W-1:0] mult_p_t;

  // Sum of three product-width terms; cannot overflow for 16x9 operands.
  function automatic mult_p_t add3(input mult_p_t x, input mult_p_t y, input mult_p_t z);
    return x + y + z;
  endfunction

endpackage

// File: rtl/mult_16x9_if.sv
// rtl/mult_16x9_if.sv - operand/product bus for the 16x9 multiplier
interface mult_16x9_if;
  import img_proc_pkg::*;

  logic    in_valid;
  mult_a_t a_16b;
  mult_b_t b_9b;
  mult_p_t c;
  logic    out_valid;

  // Producer side: drives operands, observes the product.
  modport master (
    output in_valid, a_16b, b_9b,
    input  c, out_valid
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a_16b, b_9b,
    output c, out_valid
  );

endinterface

// File: rtl/mult_16x9_pp_gen.sv
// rtl/mult_16x9_pp_gen.sv - combinational partial-product rows for a 16x9 multiply
module mult_pp_gen
  import img_proc_pkg::*;
(
  input  mult_a_t                          a_i,
  input  mult_b_t                          b_i,
  output logic [MULT_B_W-1:0][MULT_P_W-1:0] pp_o
);

  // Row i is the multiplicand shifted by i, kept only when multiplier bit i is set.
  for (genvar i = 0; i < MULT_B_W; i++) begin : g_row
    assign pp_o[i] = b_i[i] ? (MULT_P_W'(a_i) << i) : '0;
  end

endmodule

// File: rtl/mult_16x9.sv
// rtl/mult_16x9.sv - two-stage pipelined unsigned 16x9 multiplier, explicit adder tree
module mult_16x9
  import img_proc_pkg::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  mult_16x9_if.slave   bus
);

  logic [MULT_B_W-1:0][MULT_P_W-1:0] pp;
  mult_p_t s1_d [5];
  mult_p_t s2_d [3];
  mult_p_t s2_q [3];
  logic    v1_q;
  mult_p_t c_d;
  mult_p_t c_q;
  logic    v2_q;

  mult_pp_gen u_pp_gen (
    .a_i  (bus.a_16b),
    .b_i  (bus.b_9b),
    .pp_o (pp)
  );

  // First two adder-tree levels, ahead of the P1 cut.
  always_comb begin
    s1_d[0] = pp[0] + pp[1];
    s1_d[1] = pp[2] + pp[3];
    s1_d[2] = pp[4] + pp[5];
    s1_d[3] = pp[6] + pp[7];
    s1_d[4] = pp[8];
    s2_d[0] = s1_d[0] + s1_d[1];
    s2_d[1] = s1_d[2] + s1_d[3];
    s2_d[2] = s1_d[4];
  end

  // P1: data loads every cycle; valid only qualifies it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s2_q[0] <= '0;
      s2_q[1] <= '0;
      s2_q[2] <= '0;
      v1_q    <= 1'b0;
    end else begin
      s2_q[0] <= s2_d[0];
      s2_q[1] <= s2_d[1];
      s2_q[2] <= s2_d[2];
      v1_q    <= bus.in_valid;
    end
  end

  // Final adder level after the P1 cut.
  always_comb begin
    c_d = add3(s2_q[0], s2_q[1], s2_q[2]);
  end

  // P2: registered product and valid, so outputs come only from flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      c_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      c_q  <= c_d;
      v2_q <= v1_q;
    end
  end

  assign bus.c         = c_q;
  assign bus.out_valid = v2_q;

endmodule

// File: tb/tb_mult_16x9.sv
// tb/tb_mult_16x9.sv - directed and soak bench for mult_16x9
module tb_mult_16x9;
  import img_proc_pkg::*;

  logic sys_clk;
  logic sys_rst_n;
  int   total;
  int   bad;

  mult_16x9_if bus ();

  mult_16x9 dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic drive(input logic v, input logic [15:0] a, input logic [8:0] b);
    bus.in_valid = v;
    bus.a_16b    = a;
    bus.b_9b     = b;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    drive(1'b1, 16'($urandom), 9'($urandom));
    #3;
    total++;
    if (bus.c !== 25'd0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async c=%0d ov=%b required c=0 ov=0", bus.c, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 9'($urandom));
      tick();
      total++;
      if (bus.c !== 25'd0 || bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_held c=%0d ov=%b required c=0 ov=0", bus.c, bus.out_valid);
      end
    end
    drive(1'b0, 16'd0, 9'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle ov=%b required 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta [5];
    logic [8:0]  tb [5];
    logic [24:0] te [5];
    ta = '{16'd0, 16'd65535, 16'd1, 16'd65535, 16'd1234};
    tb = '{9'd511, 9'd0,     9'd1,  9'd511,    9'd300};
    te = '{25'd0,  25'd0,    25'd1, 25'd33488385, 25'd370200};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ta[k], tb[k]);
      tick();
      drive(1'b0, 16'd0, 9'd0);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL corner_early k=%0d ov=%b required 0", k, bus.out_valid);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.c !== te[k]) begin
        bad++;
        $display("FAIL corner k=%0d c=%0d ov=%b required c=%0d ov=1", k, bus.c, bus.out_valid, te[k]);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL corner_late k=%0d ov=%b required 0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    nvalid = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 5) drive(1'b1, 16'(cyc + 1), 9'd2);
      else         drive(1'b0, 16'd0, 9'd0);
      tick();
      if (bus.out_valid === 1'b1) nvalid++;
      total++;
      if (bus.out_valid !== (cyc >= 1 && cyc <= 5)) begin
        bad++;
        $display("FAIL stream_valid cyc=%0d ov=%b", cyc, bus.out_valid);
      end
      if (cyc >= 1 && cyc <= 5) begin
        total++;
        if (bus.c !== 25'(2 * cyc)) begin
          bad++;
          $display("FAIL stream_data cyc=%0d c=%0d required %0d", cyc, bus.c, 2 * cyc);
        end
      end
    end
    total++;
    if (nvalid != 5) begin
      bad++;
      $display("FAIL stream_count got=%0d required 5", nvalid);
    end
  endtask

  task automatic test_bit_isolation();
    logic [24:0] full;
    full = 25'h000FFFF;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 9) drive(1'b1, 16'hFFFF, 9'(1 << cyc));
      else         drive(1'b0, 16'd0, 9'd0);
      tick();
      if (cyc >= 1 && cyc <= 9) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.c !== (full << (cyc - 1))) begin
          bad++;
          $display("FAIL bit_row i=%0d c=%h ov=%b required c=%h", cyc - 1, bus.c, bus.out_valid, full << (cyc - 1));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 16'd100, 9'd3);
    tick();
    drive(1'b1, 16'd200, 9'd5);
    #2;
    sys_rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.c !== 25'd0) begin
      bad++;
      $display("FAIL midrst_clear c=%0d ov=%b required c=0 ov=0", bus.c, bus.out_valid);
    end
    tick();
    drive(1'b0, 16'd0, 9'd0);
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_leak i=%0d c=%0d ov=%b required ov=0", i, bus.c, bus.out_valid);
      end
    end
    drive(1'b1, 16'd7, 9'd9);
    tick();
    drive(1'b0, 16'd0, 9'd0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_early ov=%b required 0", bus.out_valid);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.c !== 25'd63) begin
      bad++;
      $display("FAIL midrst_first c=%0d ov=%b required c=63 ov=1", bus.c, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_soak();
    logic [15:0] a;
    logic [8:0]  b;
    logic [24:0] prev_p;
    logic        prev_v;
    int          soak_bad;
    prev_p   = '0;
    prev_v   = 1'b0;
    soak_bad = 0;
    for (int n = 0; n <= 65536; n++) begin
      a = 16'($urandom);
      b = 9'($urandom);
      if (n < 65536) drive(1'b1, a, b);
      else           drive(1'b0, 16'd0, 9'd0);
      tick();
      total++;
      if (bus.out_valid !== prev_v || (prev_v && bus.c !== prev_p)) begin
        bad++;
        soak_bad++;
        if (soak_bad <= 10)
          $display("FAIL soak n=%0d c=%0d ov=%b required c=%0d ov=%b", n, bus.c, bus.out_valid, prev_p, prev_v);
      end
      prev_v = (n < 65536);
      prev_p = 25'(a) * 25'(b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 16'd0, 9'd0);
    sys_rst_n = 1'b1;
    #2;
    test_reset();
    test_corners();
    test_back_to_back();
    test_bit_isolation();
    test_reset_midstream();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
